// File: rtl/fifo_packer_pkg.sv
// fifo_packer_pkg: shared definitions for the FIFO word packer and its matching
// unpacker.
//   FP_WIDTH_DEF / FP_RATIO_DEF : default lane width and lanes per output word
//   `FP_CNT_W(ratio)            : width of a lane count holding 0..ratio
//   `FP_LANE(idx, width)        : indexed part-select of lane idx in a packed vector
//   emit_e                      : which kind of word the output register loads
`ifndef FIFO_PACKER_PKG_SV
`define FIFO_PACKER_PKG_SV

`define FP_CNT_W(ratio) ($clog2((ratio) + 1))
`define FP_LANE(idx, width) (int'(idx) * (width)) +: (width)

package fifo_packer_pkg;

  localparam int FP_WIDTH_DEF = 8;
  localparam int FP_RATIO_DEF = 4;

  typedef enum logic [1:0] {
    EMIT_NONE = 2'd0,
    EMIT_FULL = 2'd1,
    EMIT_PART = 2'd2
  } emit_e;

endpackage

`endif

// File: rtl/fifo1.sv
// fifo1: small show-ahead synchronous FIFO (DEPTH must be a power of two).
//   clk, rst_n : clock, asynchronous active-low reset
//   push, d_in : write strobe and data (ignored while full)
//   pop        : acknowledge head word (ignored while empty)
//   d_out      : head word, valid whenever !empty
//   full, empty: occupancy flags
module fifo1 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] d_in,
  input  logic             pop,
  output logic [WIDTH-1:0] d_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign d_out   = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array write.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= d_in;
    end
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_packer.sv
// fifo_packer: pops WIDTH-bit words from a show-ahead FIFO and packs RATIO of
// them into one WIDTH*RATIO-bit word on a valid/ready stream. A flush pulse
// emits the trailing partial word (with its lane count) once the FIFO drains.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fifo_empty, fifo_d  : upstream FIFO flag and head word
//   fifo_pop            : combinational pop strobe to the FIFO
//   flush               : single-cycle request to emit the pending partial word
//   out_valid/out_ready : output handshake
//   out_data            : packed word, lane 0 (LSBs) = oldest FIFO word
//   out_cnt             : number of valid lanes (1..RATIO) while out_valid
//   busy                : partial word held, flush pending or output occupied
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH_DEF,
  parameter int RATIO = FP_RATIO_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  input  logic [WIDTH-1:0]             fifo_d,
  output logic                         fifo_pop,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*RATIO-1:0]       out_data,
  output logic [`FP_CNT_W(RATIO)-1:0]  out_cnt,
  output logic                         busy
);

  localparam int                IDX_W    = $clog2(RATIO);
  localparam int                CNT_W    = `FP_CNT_W(RATIO);
  localparam int                ACC_W    = WIDTH * (RATIO - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RATIO);

  // Lanes 0..RATIO-2 live in acc; the last lane comes straight from fifo_d.
  logic [ACC_W-1:0]       acc_r;
  logic [IDX_W-1:0]       idx_r;
  logic                   flush_pend_r;
  logic                   out_valid_r;
  logic [WIDTH*RATIO-1:0] out_data_r;
  logic [CNT_W-1:0]       out_cnt_r;

  logic  out_free_s;
  logic  last_lane_s;
  logic  pop_s;
  logic  flush_svc_s;
  logic  accept_s;
  emit_e emit_s;

  // Pop/flush decisions and the kind of word the output register loads.
  always_comb begin
    out_free_s  = !out_valid_r || out_ready;
    last_lane_s = (idx_r == IDX_LAST);
    accept_s    = out_valid_r && out_ready;
    // Only the completing word has to wait for room in the output register.
    pop_s       = !fifo_empty && (!last_lane_s || out_free_s);
    // Flush is serviced only when no pop can happen this cycle.
    flush_svc_s = flush_pend_r && fifo_empty && out_free_s;
    if (pop_s && last_lane_s) begin
      emit_s = EMIT_FULL;
    end else if (flush_svc_s && (idx_r != {IDX_W{1'b0}})) begin
      emit_s = EMIT_PART;
    end else begin
      emit_s = EMIT_NONE;
    end
  end

  // Lane accumulation, output register and flush bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= {ACC_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      flush_pend_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {(WIDTH * RATIO){1'b0}};
      out_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (emit_s)
        EMIT_FULL: begin
          out_data_r  <= {fifo_d, acc_r};
          out_cnt_r   <= CNT_FULL;
          out_valid_r <= 1'b1;
          acc_r       <= {ACC_W{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
        end
        EMIT_PART: begin
          // acc lanes at and above idx are already zero, so the upper lanes
          // come out zero-filled without masking.
          out_data_r  <= {{WIDTH{1'b0}}, acc_r};
          out_cnt_r   <= CNT_W'(idx_r);
          out_valid_r <= 1'b1;
          acc_r       <= {ACC_W{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
        end
        default: begin
          // Here a pop always has idx < RATIO-1, so the lane lies inside acc.
          if (pop_s) begin
            acc_r[`FP_LANE(idx_r, WIDTH)] <= fifo_d;
            idx_r <= idx_r + IDX_W'(1);
          end
          if (accept_s) begin
            out_valid_r <= 1'b0;
          end
        end
      endcase

      // A flush arriving while one is pending is absorbed.
      if (flush_svc_s) begin
        flush_pend_r <= 1'b0;
      end else if (flush) begin
        flush_pend_r <= 1'b1;
      end
    end
  end

  assign fifo_pop  = pop_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_cnt   = out_cnt_r;
  assign busy      = (idx_r != {IDX_W{1'b0}}) || flush_pend_r || out_valid_r;

endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: directed test of fifo_packer (RATIO=4 and RATIO=3 builds),
// each fed by a fifo1 instance.
module tb_fifo_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // RATIO = 4 path
  logic        f4_push = 1'b0;
  logic [7:0]  f4_din = 8'h00;
  logic [7:0]  f4_dout;
  logic        f4_full, f4_empty;
  logic        p4_pop, p4_valid, p4_busy;
  logic        p4_flush = 1'b0;
  logic        p4_ready = 1'b0;
  logic [31:0] p4_data;
  logic [2:0]  p4_cnt;

  // RATIO = 3 path
  logic        f3_push = 1'b0;
  logic [7:0]  f3_din = 8'h00;
  logic [7:0]  f3_dout;
  logic        f3_full, f3_empty;
  logic        p3_pop, p3_valid, p3_busy;
  logic        p3_flush = 1'b0;
  logic        p3_ready = 1'b0;
  logic [23:0] p3_data;
  logic [1:0]  p3_cnt;

  fifo1 #(.WIDTH(8), .DEPTH(4)) f4 (
    .clk(clk), .rst_n(rst_n), .push(f4_push), .d_in(f4_din), .pop(p4_pop),
    .d_out(f4_dout), .full(f4_full), .empty(f4_empty)
  );

  fifo_packer #(.WIDTH(8), .RATIO(4)) u4 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(f4_empty), .fifo_d(f4_dout),
    .fifo_pop(p4_pop), .flush(p4_flush), .out_valid(p4_valid),
    .out_ready(p4_ready), .out_data(p4_data), .out_cnt(p4_cnt), .busy(p4_busy)
  );

  fifo1 #(.WIDTH(8), .DEPTH(4)) f3 (
    .clk(clk), .rst_n(rst_n), .push(f3_push), .d_in(f3_din), .pop(p3_pop),
    .d_out(f3_dout), .full(f3_full), .empty(f3_empty)
  );

  fifo_packer #(.WIDTH(8), .RATIO(3)) u3 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(f3_empty), .fifo_d(f3_dout),
    .fifo_pop(p3_pop), .flush(p3_flush), .out_valid(p3_valid),
    .out_ready(p3_ready), .out_data(p3_data), .out_cnt(p3_cnt), .busy(p3_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] b4_data[$];
  int          b4_cnt[$];
  int          b4_cyc[$];
  int          pop4_cyc[$];
  logic [23:0] b3_data[$];
  int          b3_cnt[$];

  // Record accepted beats and pop cycles as seen just before each edge.
  always @(posedge clk) begin
    if (p4_pop) pop4_cyc.push_back(cyc);
    if (p4_valid && p4_ready) begin
      b4_data.push_back(p4_data);
      b4_cnt.push_back(int'(p4_cnt));
      b4_cyc.push_back(cyc);
    end
    if (p3_valid && p3_ready) begin
      b3_data.push_back(p3_data);
      b3_cnt.push_back(int'(p3_cnt));
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    b4_data.delete(); b4_cnt.delete(); b4_cyc.delete(); pop4_cyc.delete();
    b3_data.delete(); b3_cnt.delete();
  endtask

  // Called at a negedge; leaves at the following negedge with push dropped.
  task automatic push_byte(input bit sel3, input logic [7:0] b);
    int guard = 0;
    while ((sel3 ? f3_full : f4_full) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("push_wait_full", 64'(guard), 64'd0);
    if (sel3) begin
      f3_push = 1'b1; f3_din = b;
    end else begin
      f4_push = 1'b1; f4_din = b;
    end
    @(negedge clk);
    f3_push = 1'b0;
    f4_push = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state
    idle(2);
    #1;
    chk("rst_out_valid", 64'(p4_valid), 64'd0);
    chk("rst_out_data", 64'(p4_data), 64'd0);
    chk("rst_out_cnt", 64'(p4_cnt), 64'd0);
    chk("rst_busy", 64'(p4_busy), 64'd0);
    chk("rst_fifo_pop", 64'(p4_pop), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // ---------------- one full word, ready held high
    clear_logs();
    p4_ready = 1'b1;
    push_byte(1'b0, 8'h11);
    push_byte(1'b0, 8'h22);
    push_byte(1'b0, 8'h33);
    push_byte(1'b0, 8'h44);
    idle(6);
    chk("t1_beats", 64'(b4_data.size()), 64'd1);
    chk("t1_data", 64'(b4_data[0]), 64'h44332211);
    chk("t1_cnt", 64'(b4_cnt[0]), 64'd4);
    chk("t1_pops", 64'(pop4_cyc.size()), 64'd4);
    chk("t1_latency", 64'(b4_cyc[0] - pop4_cyc[3]), 64'd1);
    #1;
    chk("t1_busy_after", 64'(p4_busy), 64'd0);

    // ---------------- back-pressure: two words with ready low
    @(negedge clk);
    clear_logs();
    p4_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(1'b0, 8'(i));
    idle(6);
    #1;
    chk("t2_hold_valid", 64'(p4_valid), 64'd1);
    chk("t2_hold_data", 64'(p4_data), 64'h04030201);
    chk("t2_hold_cnt", 64'(p4_cnt), 64'd4);
    chk("t2_stall_pop", 64'(p4_pop), 64'd0);
    chk("t2_stall_fifo_nonempty", 64'(f4_empty), 64'd0);
    chk("t2_pops_before_release", 64'(pop4_cyc.size()), 64'd7);
    idle(3);
    #1;
    chk("t2_data_stable", 64'(p4_data), 64'h04030201);
    chk("t2_no_beats_yet", 64'(b4_data.size()), 64'd0);
    @(negedge clk);
    p4_ready = 1'b1;
    idle(6);
    chk("t2_beats", 64'(b4_data.size()), 64'd2);
    chk("t2_beat0", 64'(b4_data[0]), 64'h04030201);
    chk("t2_beat1", 64'(b4_data[1]), 64'h08070605);
    chk("t2_cnt1", 64'(b4_cnt[1]), 64'd4);
    chk("t2_back_to_back", 64'(b4_cyc[1] - b4_cyc[0]), 64'd1);

    // ---------------- partial word flush
    clear_logs();
    push_byte(1'b0, 8'hAA);
    push_byte(1'b0, 8'hBB);
    idle(4);
    p4_flush = 1'b1;
    @(negedge clk);
    p4_flush = 1'b0;
    idle(4);
    chk("t3_beats", 64'(b4_data.size()), 64'd1);
    chk("t3_data", 64'(b4_data[0]), 64'h0000BBAA);
    chk("t3_cnt", 64'(b4_cnt[0]), 64'd2);
    #1;
    chk("t3_busy_after", 64'(p4_busy), 64'd0);

    // ---------------- flush while bytes are still queued
    @(negedge clk);
    clear_logs();
    p4_flush = 1'b1;
    push_byte(1'b0, 8'h01);
    p4_flush = 1'b0;
    for (int i = 2; i <= 5; i++) push_byte(1'b0, 8'(i));
    idle(8);
    chk("t4_beats", 64'(b4_data.size()), 64'd2);
    chk("t4_beat0", 64'(b4_data[0]), 64'h04030201);
    chk("t4_cnt0", 64'(b4_cnt[0]), 64'd4);
    chk("t4_beat1", 64'(b4_data[1]), 64'h00000005);
    chk("t4_cnt1", 64'(b4_cnt[1]), 64'd1);

    // flush with nothing pending: busy for one cycle, no output
    p4_flush = 1'b1;
    @(negedge clk);
    p4_flush = 1'b0;
    #1;
    chk("t4_empty_flush_pending", 64'(p4_busy), 64'd1);
    idle(5);
    chk("t4_empty_flush_no_beat", 64'(b4_data.size()), 64'd2);
    #1;
    chk("t4_empty_flush_busy", 64'(p4_busy), 64'd0);

    // ---------------- reset mid-packing discards the partial word
    @(negedge clk);
    clear_logs();
    push_byte(1'b0, 8'hE1);
    push_byte(1'b0, 8'hE2);
    push_byte(1'b0, 8'hE3);
    idle(3);
    #1;
    chk("t5_busy_before_rst", 64'(p4_busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_in_rst", 64'(p4_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    push_byte(1'b0, 8'h10);
    push_byte(1'b0, 8'h20);
    push_byte(1'b0, 8'h30);
    push_byte(1'b0, 8'h40);
    idle(6);
    chk("t5_beats", 64'(b4_data.size()), 64'd1);
    chk("t5_data", 64'(b4_data[0]), 64'h40302010);
    chk("t5_cnt", 64'(b4_cnt[0]), 64'd4);

    // ---------------- RATIO = 3 build
    clear_logs();
    p3_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push_byte(1'b1, 8'(i));
    idle(6);
    chk("t6_beats", 64'(b3_data.size()), 64'd2);
    chk("t6_beat0", 64'(b3_data[0]), 64'h030201);
    chk("t6_cnt0", 64'(b3_cnt[0]), 64'd3);
    chk("t6_beat1", 64'(b3_data[1]), 64'h060504);
    chk("t6_cnt1", 64'(b3_cnt[1]), 64'd3);
    #1;
    chk("t6_busy_after", 64'(p3_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
